regwrite_checker: RTL and testbench
===================================

// Module: regwrite_checker
// PURPOSE
//  Synthesizable self-checker placed beside the skeleton processor. It observes the
//  regfile write port (ctrl_writeEnable/ctrl_writeReg/data_writeReg) and compares each
//  write, in order, against an expected-write table loaded beforehand.
//  It produces the pass/fail and error counts that the bench currently tallies by hand,
//  so on-board runs self-report.
// PARAMETERS
//  DEPTH    64    expected-table entries ({reg[4:0], data[31:0]} each)
//  AW       6     log2(DEPTH); index width
//  TIMEOUT  1024  max cycles between checked writes in CHECK (used only with macro)
// PORTS
//  clock             in   1    single clock; all state updates on posedge
//  reset             in   1    synchronous, active-high
//  start             in   1    1-cycle pulse, IDLE -> CHECK
//  exp_wr_en         in   1    load one expected entry (IDLE only)
//  exp_wr_reg        in   5    expected destination register
//  exp_wr_data       in   32   expected write data
//  ctrl_writeEnable  in   1    processor regfile write enable
//  ctrl_writeReg     in   5    processor regfile write address
//  data_writeReg     in   32   processor regfile write data
//  load_count        out  AW+1 entries loaded so far
//  load_full         out  1    load_count == DEPTH
//  busy              out  1    state == CHECK
//  done              out  1    state == DONE
//  pass              out  1    valid when done: all entries matched, no overrun
//  error_count       out  16   mismatches, saturating at 16'hFFFF
//  match_count       out  16   matches, saturating at 16'hFFFF
//  fail_valid        out  1    first-mismatch capture valid
//  fail_index        out  AW   table index of first mismatch
//  fail_reg          out  5    observed ctrl_writeReg at first mismatch
//  fail_data         out  32   observed data_writeReg at first mismatch
//  overrun           out  1    qualifying write seen in DONE
//  timeout           out  1    watchdog fired (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0; load/check pointers 0. Table RAM contents
//    are not cleared, but they are unreachable because load_count=0.
//    Reset mid-CHECK or mid-DONE aborts immediately to IDLE.
//  - Qualifying write: ctrl_writeEnable=1 and ctrl_writeReg!=0. Writes to r0 are
//    ignored in every state.
//  - IDLE:
//    - exp_wr_en stores {exp_wr_reg, exp_wr_data} at load_count and increments it.
//    - When load_full, the write is dropped and load_count holds.
//    - exp_wr_en is ignored in all other states.
//  - start in IDLE:
//    - With load_count>0: go to CHECK next cycle with check_ptr=0.
//    - With load_count==0: go to DONE with pass=1.
//    - start and exp_wr_en in the same cycle: the entry is stored first, and the
//      count used is load_count+1.
//    - start outside IDLE is ignored.
//  - CHECK, per qualifying write:
//    - Compare {reg,data} against entry[check_ptr]. Equal -> match_count++; else
//      error_count++.
//    - On the first mismatch only: latch fail_index/fail_reg/fail_data and set fail_valid.
//    - Then check_ptr++.
//    - Non-qualifying cycles change nothing.
//  - Completion: when the write at check_ptr==load_count-1 is consumed, enter DONE
//    the next cycle. pass = (error_count==0 including that final compare).
//    All counters are registered and visible 1 cycle after the write.
//  - DONE:
//    - A qualifying write sets overrun=1 and pass=0 (sticky). Counters are frozen.
//    - State holds until reset.
//  - Counters saturate; they never wrap.
// CONFIGURATION
//  REGCHK_TIMEOUT_EN defined:
//    - In CHECK, a watchdog counts cycles since the last qualifying write (or since
//      entering CHECK).
//    - When it reaches TIMEOUT: timeout=1, pass=0, state -> DONE.
//    - The watchdog resets on every qualifying write.
//  REGCHK_TIMEOUT_EN undefined:
//    - No watchdog logic is built; timeout is tied to 0.
//    - CHECK waits indefinitely.
// TESTING
//  1 Load 3 entries (r1=5, r2=7, r3=12); start; drive the same 3 writes -> match_count=3,
//    error_count=0, done=1 and pass=1 the cycle after the 3rd write.
//  2 Same table; 2nd write r2=8 -> error_count=1, fail_valid=1, fail_index=1,
//    fail_reg=2, fail_data=8, pass=0 at done.
//  3 Writes to r0 interleaved in CHECK -> counts unchanged; in DONE, a write to r0 does
//    not set overrun; a write to r4 sets overrun=1 and pass=0.
//  4 Load DEPTH+2 entries -> load_full=1, load_count=DEPTH. start with an empty table
//    -> done=1, pass=1 next cycle. start+exp_wr_en same cycle -> load_count=1, CHECK.
//  5 Reset asserted after 1 of 3 checked writes -> next cycle: IDLE, all outputs 0,
//    load_count=0.
//  6 With REGCHK_TIMEOUT_EN, TIMEOUT=16: start, then no writes -> timeout=1, done=1,
//    pass=0 exactly 16 cycles after entering CHECK.

Source files
------------

// File: rtl/regwrite_checker_if.sv
// Bus bundle for regwrite_checker: the expected-table load port, the start
// pulse, the observed processor regfile write port, and the checker status.
//   master : table loader / processor side (drives inputs, reads status)
//   slave  : the checker (reads inputs, drives status)
interface regwrite_checker_if #(parameter int AW = 6);
  logic          start;
  logic          exp_wr_en;
  logic [4:0]    exp_wr_reg;
  logic [31:0]   exp_wr_data;
  logic          ctrl_writeEnable;
  logic [4:0]    ctrl_writeReg;
  logic [31:0]   data_writeReg;
  logic [AW:0]   load_count;
  logic          load_full;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   error_count;
  logic [15:0]   match_count;
  logic          fail_valid;
  logic [AW-1:0] fail_index;
  logic [4:0]    fail_reg;
  logic [31:0]   fail_data;
  logic          overrun;
  logic          timeout;

  modport master (
    output start, exp_wr_en, exp_wr_reg, exp_wr_data,
           ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  load_count, load_full, busy, done, pass, error_count, match_count,
           fail_valid, fail_index, fail_reg, fail_data, overrun, timeout
  );

  modport slave (
    input  start, exp_wr_en, exp_wr_reg, exp_wr_data,
           ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output load_count, load_full, busy, done, pass, error_count, match_count,
           fail_valid, fail_index, fail_reg, fail_data, overrun, timeout
  );
endinterface

// File: rtl/regwrite_checker.sv
// regwrite_checker: compares each regfile write of the processor, in order,
// against a preloaded table of expected {reg, data} entries and reports
// match/error counts, the first mismatch, overrun and an overall pass flag.
// Ports:
//   clock  - single clock, posedge
//   reset  - synchronous, active-high; aborts any run back to IDLE
//   bus    - regwrite_checker_if.slave (load port, start, observed write
//            port, status outputs)
// Optional feature: define REGCHK_TIMEOUT_EN to build a CHECK-state
// watchdog that ends the run (timeout=1, pass=0) after TIMEOUT cycles
// without a qualifying write. Without it, timeout is tied to 0.
module regwrite_checker #(
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int TIMEOUT = 1024
) (
  input logic              clock,
  input logic              reset,
  regwrite_checker_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   load_cnt_q, load_cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [15:0]   err_q, err_d, match_q, match_d;
  logic          fv_q, fv_d;
  logic [AW-1:0] fidx_q, fidx_d;
  logic [4:0]    freg_q, freg_d;
  logic [31:0]   fdata_q, fdata_d;
  logic          overrun_q, overrun_d;
  logic          pass_q, pass_d;

  logic [36:0]   mem [DEPTH];
  logic [36:0]   entry;
  logic          qual, load_full, load_we, hit;

`ifdef REGCHK_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          tmo_q, tmo_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
`endif

  // writes to r0 never count as real writes
  assign qual      = bus.ctrl_writeEnable && (bus.ctrl_writeReg != 5'd0);
  assign load_full = (load_cnt_q == (AW+1)'(DEPTH));
  assign entry     = mem[ptr_q];

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    ptr_d      = ptr_q;
    err_d      = err_q;
    match_d    = match_q;
    fv_d       = fv_q;
    fidx_d     = fidx_q;
    freg_d     = freg_q;
    fdata_d    = fdata_q;
    overrun_d  = overrun_q;
    pass_d     = pass_q;
    load_we    = 1'b0;
    hit        = 1'b0;
`ifdef REGCHK_TIMEOUT_EN
    wdog_d     = wdog_q;
    tmo_d      = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        load_we = bus.exp_wr_en && !load_full;
        if (load_we) load_cnt_d = load_cnt_q + 1'b1;
        // start sees the count including a same-cycle load
        if (bus.start) begin
          ptr_d = '0;
          if (load_cnt_d == '0) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = S_CHECK;
          end
        end
`ifdef REGCHK_TIMEOUT_EN
        wdog_d = '0;
`endif
      end
      S_CHECK: begin
        if (qual) begin
          hit = (entry == {bus.ctrl_writeReg, bus.data_writeReg});
          if (hit) begin
            if (match_q != 16'hFFFF) match_d = match_q + 16'd1;
          end else begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (!fv_q) begin
              fv_d    = 1'b1;
              fidx_d  = ptr_q;
              freg_d  = bus.ctrl_writeReg;
              fdata_d = bus.data_writeReg;
            end
          end
          ptr_d = ptr_q + 1'b1;
          if ({1'b0, ptr_q} == (load_cnt_q - 1'b1)) begin
            state_d = S_DONE;
            // err_q saturates, so zero here means no earlier mismatch
            pass_d  = (err_q == 16'd0) && hit;
          end
`ifdef REGCHK_TIMEOUT_EN
          wdog_d = '0;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          wdog_d = wdog_q + 1'b1;
`endif
        end
      end
      S_DONE: begin
        if (qual) begin
          overrun_d = 1'b1;
          pass_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      ptr_q      <= '0;
      err_q      <= '0;
      match_q    <= '0;
      fv_q       <= 1'b0;
      fidx_q     <= '0;
      freg_q     <= '0;
      fdata_q    <= '0;
      overrun_q  <= 1'b0;
      pass_q     <= 1'b0;
`ifdef REGCHK_TIMEOUT_EN
      wdog_q     <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
      match_q    <= match_d;
      fv_q       <= fv_d;
      fidx_q     <= fidx_d;
      freg_q     <= freg_d;
      fdata_q    <= fdata_d;
      overrun_q  <= overrun_d;
      pass_q     <= pass_d;
`ifdef REGCHK_TIMEOUT_EN
      wdog_q     <= wdog_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  // table storage is not reset; load_count gates what is reachable
  always_ff @(posedge clock) begin
    if (!reset && load_we) mem[load_cnt_q[AW-1:0]] <= {bus.exp_wr_reg, bus.exp_wr_data};
  end

  assign bus.load_count  = load_cnt_q;
  assign bus.load_full   = load_full;
  assign bus.busy        = (state_q == S_CHECK);
  assign bus.done        = (state_q == S_DONE);
  assign bus.pass        = pass_q;
  assign bus.error_count = err_q;
  assign bus.match_count = match_q;
  assign bus.fail_valid  = fv_q;
  assign bus.fail_index  = fidx_q;
  assign bus.fail_reg    = freg_q;
  assign bus.fail_data   = fdata_q;
  assign bus.overrun     = overrun_q;
`ifdef REGCHK_TIMEOUT_EN
  assign bus.timeout     = tmo_q;
`else
  assign bus.timeout     = 1'b0;
`endif
endmodule

// File: tb/tb_regwrite_checker.sv
module tb_regwrite_checker;
`ifdef REGCHK_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif
  localparam int DEPTH = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  regwrite_checker_if #(.AW(6)) bus ();
  regwrite_checker #(.DEPTH(DEPTH), .AW(6), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic [2:0][4:0]  wr;
    logic [2:0][31:0] wd;
    logic [15:0]      em, ee;
    logic             ep, efv;
    logic [5:0]       efi;
    logic [4:0]       efr;
    logic [31:0]      efd;
  } case_t;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb [$];

  // reference table and scoreboard model
  logic [4:0]  tbl_r [3] = '{5'd1, 5'd2, 5'd3};
  logic [31:0] tbl_d [3] = '{32'd5, 32'd7, 32'd12};
  int m_ptr, m_match, m_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.exp_wr_en = 1'b0; bus.ctrl_writeEnable = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    m_ptr = 0; m_match = 0; m_err = 0;
    sb.delete();
  endtask

  task automatic load(input logic [4:0] r, input logic [31:0] d);
    bus.exp_wr_en = 1'b1; bus.exp_wr_reg = r; bus.exp_wr_data = d;
    @(posedge clock); #1;
    bus.exp_wr_en = 1'b0;
  endtask

  task automatic load3();
    for (int i = 0; i < 3; i++) load(tbl_r[i], tbl_d[i]);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  // one processor write; model predicts the registered counters after it
  task automatic do_write(input string nm, input logic [4:0] r, input logic [31:0] d);
    logic [31:0] exp;
    bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = r; bus.data_writeReg = d;
    if (r != 5'd0 && m_ptr < 3) begin
      if (r == tbl_r[m_ptr] && d == tbl_d[m_ptr]) m_match++;
      else m_err++;
      m_ptr++;
    end
    sb.push_back({m_match[15:0], m_err[15:0]});
    @(posedge clock); #1;
    bus.ctrl_writeEnable = 1'b0;
    exp = sb.pop_front();
    chk(nm, {bus.match_count, bus.error_count}, exp);
  endtask

  case_t cases [4];

  initial begin
    bus.start = 1'b0; bus.exp_wr_en = 1'b0; bus.exp_wr_reg = '0; bus.exp_wr_data = '0;
    bus.ctrl_writeEnable = 1'b0; bus.ctrl_writeReg = '0; bus.data_writeReg = '0;

    cases[0] = '{wr:{5'd3,5'd2,5'd1}, wd:{32'd12,32'd7,32'd5}, em:16'd3, ee:16'd0,
                 ep:1'b1, efv:1'b0, efi:6'd0, efr:5'd0, efd:32'd0};
    cases[1] = '{wr:{5'd3,5'd2,5'd1}, wd:{32'd12,32'd8,32'd5}, em:16'd2, ee:16'd1,
                 ep:1'b0, efv:1'b1, efi:6'd1, efr:5'd2, efd:32'd8};
    cases[2] = '{wr:{5'd3,5'd9,5'd1}, wd:{32'd13,32'd7,32'd6}, em:16'd0, ee:16'd3,
                 ep:1'b0, efv:1'b1, efi:6'd0, efr:5'd1, efd:32'd6};
    cases[3] = '{wr:{5'd4,5'd2,5'd1}, wd:{32'd12,32'd7,32'd5}, em:16'd2, ee:16'd1,
                 ep:1'b0, efv:1'b1, efi:6'd2, efr:5'd4, efd:32'd12};

    // reset state
    do_reset();
    chk("rst_a", {bus.load_count, bus.load_full, bus.busy, bus.done, bus.pass,
                  bus.error_count, bus.match_count}, '0);
    chk("rst_b", {bus.fail_valid, bus.fail_index, bus.fail_reg, bus.fail_data,
                  bus.overrun, bus.timeout}, '0);

    // table-driven runs of three writes
    for (int i = 0; i < 4; i++) begin
      do_reset();
      load3();
      chk($sformatf("c%0d_cnt", i), bus.load_count, 3);
      pulse_start();
      chk($sformatf("c%0d_busy", i), bus.busy, 1);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("c%0d_notdone%0d", i, k), bus.done, 0);
        do_write($sformatf("c%0d_w%0d", i, k), cases[i].wr[k], cases[i].wd[k]);
      end
      chk($sformatf("c%0d_done", i), {bus.done, bus.busy}, 2'b10);
      chk($sformatf("c%0d_pass", i), bus.pass, cases[i].ep);
      chk($sformatf("c%0d_counts", i), {bus.match_count, bus.error_count},
          {cases[i].em, cases[i].ee});
      chk($sformatf("c%0d_fail", i), {bus.fail_valid, bus.fail_index, bus.fail_reg, bus.fail_data},
          {cases[i].efv, cases[i].efi, cases[i].efr, cases[i].efd});
    end

    // r0 writes interleaved, then overrun in DONE
    do_reset();
    load3();
    pulse_start();
    do_write("r0_w0", 5'd1, 32'd5);
    do_write("r0_i0", 5'd0, 32'd99);
    do_write("r0_w1", 5'd2, 32'd7);
    do_write("r0_i1", 5'd0, 32'd5);
    chk("r0_still_busy", bus.busy, 1);
    do_write("r0_w2", 5'd3, 32'd12);
    chk("r0_done_pass", {bus.done, bus.pass}, 2'b11);
    do_write("done_r0", 5'd0, 32'd1);
    chk("done_r0_ovr", {bus.overrun, bus.pass}, 2'b01);
    do_write("done_r4", 5'd4, 32'd1);
    chk("done_r4_ovr", {bus.overrun, bus.pass, bus.done}, 3'b101);

    // reset from DONE
    do_reset();
    chk("rst_done", {bus.done, bus.overrun, bus.pass, bus.match_count}, '0);

    // overfill the table
    bus.exp_wr_en = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      bus.exp_wr_reg = 5'(i + 1); bus.exp_wr_data = 32'(i);
      @(posedge clock); #1;
    end
    bus.exp_wr_en = 1'b0;
    chk("full", {bus.load_full, bus.load_count}, {1'b1, 7'd64});

    // empty table start
    do_reset();
    pulse_start();
    chk("empty_start", {bus.done, bus.pass, bus.busy}, 3'b110);

    // start and load in the same cycle
    do_reset();
    bus.exp_wr_en = 1'b1; bus.exp_wr_reg = 5'd1; bus.exp_wr_data = 32'd5;
    pulse_start();
    bus.exp_wr_en = 1'b0;
    chk("start_load", {bus.load_count, bus.busy}, {7'd1, 1'b1});
    do_write("start_load_w", 5'd1, 32'd5);
    chk("start_load_done", {bus.done, bus.pass}, 2'b11);

    // reset mid-CHECK
    do_reset();
    load3();
    pulse_start();
    do_write("mid_w0", 5'd1, 32'd5);
    do_reset();
    chk("mid_rst_a", {bus.load_count, bus.load_full, bus.busy, bus.done, bus.pass,
                      bus.error_count, bus.match_count}, '0);
    chk("mid_rst_b", {bus.fail_valid, bus.fail_index, bus.fail_reg, bus.fail_data,
                      bus.overrun, bus.timeout}, '0);

`ifdef REGCHK_TIMEOUT_EN
    // watchdog: no writes after start
    do_reset();
    load3();
    pulse_start();
    repeat (TO - 1) @(posedge clock);
    #1;
    chk("tmo_early", {bus.done, bus.timeout}, 2'b00);
    @(posedge clock); #1;
    chk("tmo_fire", {bus.done, bus.timeout, bus.pass}, 3'b110);
`else
    // without the watchdog CHECK waits indefinitely
    do_reset();
    load3();
    pulse_start();
    repeat (40) @(posedge clock);
    #1;
    chk("no_tmo", {bus.busy, bus.done, bus.timeout}, 3'b100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
